// File: rtl/booth_pkg.sv
// Package shared by the radix-4 Booth accumulator.
// Contents:
//   - FSM state encodings (2-bit localparam constants).
//   - Booth digit-select type.
//   - Helper that gives the Booth digit count for an operand width.
package booth_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_NEG = 2'd1;
  localparam logic [1:0] ACCUM    = 2'd2;
  localparam logic [1:0] FIN      = 2'd3;

  // Partial-product term chosen by one Booth digit.
  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } dsel_t;

  // BITLEN counts one sign-extension bit, so the multiplier Q has
  // BITLEN-1 bits. That gives (BITLEN-1)/2 radix-4 digits.
  function automatic int ndig(input int bitlen);
    return (bitlen - 1) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_accum_if.sv
// Operand/result bundle for booth_r4_accum.
// Ports:
//   master (upstream/bench side):
//     drives  in_m, in_m_neg, in_neg_valid_pulse, in_q, in_start_pulse
//     samples busy, out_prod, out_prod_valid_pulse
//   slave (multiplier side): the mirror image of master.
interface booth_r4_accum_if #(
  parameter int BITLEN = 5
);
  logic [BITLEN-1:0]         in_m;
  logic [BITLEN-1:0]         in_m_neg;
  logic                      in_neg_valid_pulse;
  logic [BITLEN-2:0]         in_q;
  logic                      in_start_pulse;
  logic                      busy;
  logic [2*(BITLEN-1)-1:0]   out_prod;
  logic                      out_prod_valid_pulse;

  modport master (
    output in_m, in_m_neg, in_neg_valid_pulse, in_q, in_start_pulse,
    input  busy, out_prod, out_prod_valid_pulse
  );

  modport slave (
    input  in_m, in_m_neg, in_neg_valid_pulse, in_q, in_start_pulse,
    output busy, out_prod, out_prod_valid_pulse
  );
endinterface

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder.
// Ports:
//   trip_i : multiplier bit triplet {q[2i+1], q[2i], q[2i-1]}
//   sel_o  : partial-product term to add for this digit
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] trip_i,
  output dsel_t      sel_o
);

  always_comb begin
    sel_o = ZERO;
    case (trip_i)
      3'b000, 3'b111: sel_o = ZERO;
      3'b001, 3'b010: sel_o = PM;
      3'b011:         sel_o = P2M;
      3'b100:         sel_o = N2M;
      3'b101, 3'b110: sel_o = NM;
      default:        sel_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_accum.sv
// Sequential radix-4 Booth multiplier. It retires one digit per cycle into
// an accumulator that is 2*(BITLEN-1) bits wide.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : booth_r4_accum_if.slave
//           operands, the -M strobe, busy, and the product with its strobe
// Configuration:
//   BOOTH_NEG_LOCAL_EN : -M is formed internally at start, and the
//                        upstream in_m_neg and in_neg_valid_pulse are ignored.
module booth_r4_accum
  import booth_pkg::*;
#(
  parameter int BITLEN = 5
) (
  input  logic             clock,
  input  logic             reset,
  booth_r4_accum_if.slave  bus
);

  localparam int NDIG = ndig(BITLEN);
  localparam int PW   = 2 * (BITLEN - 1);
  localparam int IW   = $clog2(NDIG + 1);

  logic [1:0]        state_q, state_d;
  logic [BITLEN-1:0] m_q, m_d;
  logic [BITLEN-1:0] mn_q, mn_d;
  logic [BITLEN-2:0] qr_q, qr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              pv_q, pv_d;

  // Q with the implicit Q[-1] = 0 appended below bit 0.
  logic [BITLEN-1:0] qx;
  logic [2:0]        trip;
  dsel_t             sel;
  logic [PW-1:0]     m_ext, mn_ext, term;

  assign qx     = {qr_q, 1'b0};
  assign trip   = qx[{idx_q, 1'b0} +: 3];
  assign m_ext  = {{(PW-BITLEN){m_q[BITLEN-1]}}, m_q};
  assign mn_ext = {{(PW-BITLEN){mn_q[BITLEN-1]}}, mn_q};

  booth_r4_recoder u_rec (
    .trip_i (trip),
    .sel_o  (sel)
  );

  // Sign-extend first, then shift. The +-2M terms then keep the MSB of M.
  always_comb begin
    term = '0;
    case (sel)
      PM:      term = m_ext;
      P2M:     term = m_ext << 1;
      NM:      term = mn_ext;
      N2M:     term = mn_ext << 1;
      default: term = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    mn_d    = mn_q;
    qr_d    = qr_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    prod_d  = prod_q;
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_start_pulse) begin
          m_d    = bus.in_m;
          qr_d   = bus.in_q;
          acc_d  = '0;
          idx_d  = '0;
          busy_d = 1'b1;
`ifdef BOOTH_NEG_LOCAL_EN
          mn_d    = ~bus.in_m + 1'b1;
          state_d = ACCUM;
`else
          if (bus.in_neg_valid_pulse) begin
            mn_d    = bus.in_m_neg;
            state_d = ACCUM;
          end else begin
            state_d = WAIT_NEG;
          end
`endif
        end
      end
      WAIT_NEG: begin
`ifdef BOOTH_NEG_LOCAL_EN
        // Unreachable when -M is local. Drop back to a clean idle state.
        busy_d  = 1'b0;
        state_d = IDLE;
`else
        if (bus.in_neg_valid_pulse) begin
          mn_d    = bus.in_m_neg;
          state_d = ACCUM;
        end
`endif
      end
      ACCUM: begin
        acc_d = acc_q + (term << {idx_q, 1'b0});
        if (idx_q == IW'(NDIG - 1)) state_d = FIN;
        else                        idx_d   = idx_q + 1'b1;
      end
      FIN: begin
        prod_d  = acc_q;
        pv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      mn_q    <= '0;
      qr_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      mn_q    <= mn_d;
      qr_q    <= qr_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
    end
  end

  assign bus.busy                 = busy_q;
  assign bus.out_prod             = prod_q;
  assign bus.out_prod_valid_pulse = pv_q;

endmodule

// File: doc/booth_r4_accum.md
BOOTH_R4_ACCUM -- requirements
Module: booth_r4_accum

Interface
REQ-001 Parameter BITLEN, default 5: operand width including one sign-extension bit; SHALL be odd and >= 3; NDIG = (BITLEN-1)/2 Booth digits.
REQ-002 clock  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_m  input  BITLEN  sign-extended two's-complement multiplicand M.
REQ-005 in_m_neg  input  BITLEN  -M, produced by the upstream negation stage.
REQ-006 in_neg_valid_pulse  input  1  one-cycle strobe: in_m_neg is valid this cycle.
REQ-007 in_q  input  BITLEN-1  two's-complement multiplier Q.
REQ-008 in_start_pulse  input  1  one-cycle strobe: in_m and in_q are valid this cycle.
REQ-009 busy  output  1  high from the accepted start until the product strobe.
REQ-010 out_prod  output  2*(BITLEN-1)  signed product M*Q.
REQ-011 out_prod_valid_pulse  output  1  one-cycle strobe: out_prod is updated.

Function
REQ-012 States SHALL be IDLE, WAIT_NEG, ACCUM and FIN; any other encoding SHALL return to IDLE on the next edge.
REQ-013 In IDLE, in_start_pulse SHALL:
- latch M and Q;
- clear the accumulator and digit index;
- set busy.
If in_neg_valid_pulse is high in the same cycle, the block SHALL latch -M and go to ACCUM; otherwise it SHALL go to WAIT_NEG.
REQ-014 In WAIT_NEG, in_neg_valid_pulse SHALL latch -M and go to ACCUM; the block SHALL wait indefinitely otherwise.
REQ-015 In ACCUM, the block SHALL retire exactly one digit i per cycle, for i = 0..NDIG-1:
- the digit uses the triplet {Q[2i+1], Q[2i], Q[2i-1]}, with Q[-1] = 0;
- the selected term is 0, +M, +2M, -M or -2M, using the standard radix-4 Booth mapping;
- the term is sign-extended to 2*(BITLEN-1) bits, shifted left by 2i and added modulo 2^(2*(BITLEN-1)).
REQ-016 2M and -2M SHALL be formed by shifting M and -M left by one bit, with sign extension and no loss of the MSB.
REQ-017 After digit NDIG-1 the block SHALL go to FIN.
REQ-018 In FIN, the block SHALL:
- load out_prod from the accumulator;
- drive out_prod_valid_pulse high for exactly one cycle;
- clear busy and return to IDLE.
REQ-019 Latency: let edge j be the edge that latches -M. out_prod_valid_pulse SHALL be registered high at edge j+NDIG+1.
REQ-020 in_start_pulse outside IDLE SHALL be ignored.
REQ-021 in_neg_valid_pulse outside WAIT_NEG, and outside the IDLE start cycle, SHALL be ignored.
REQ-022 out_prod SHALL hold its last value between strobes; out_prod_valid_pulse SHALL default low every cycle.
REQ-023 A start SHALL be accepted in the cycle immediately after FIN.

Reset
REQ-024 reset high at a rising edge SHALL set:
- state = IDLE;
- busy = 0, out_prod = 0, out_prod_valid_pulse = 0;
- accumulator = 0, digit index = 0.
REQ-025 reset SHALL take priority over all inputs; a reset during WAIT_NEG or ACCUM SHALL abort the operation with no strobe.

Configuration
REQ-026 With the macro BOOTH_NEG_LOCAL_EN defined:
- -M SHALL be computed internally as ~in_m + 1 and latched at start;
- IDLE SHALL go directly to ACCUM;
- in_m_neg and in_neg_valid_pulse SHALL be ignored, and WAIT_NEG SHALL be unreachable.
REQ-027 With BOOTH_NEG_LOCAL_EN undefined, the behaviour SHALL be exactly REQ-013..REQ-021.

Structure
REQ-028 Shared package booth_pkg SHALL hold:
- the state encoding constants;
- the digit-select type (ZERO, PM, P2M, NM, N2M);
- the NDIG derivation.
REQ-029 The triplet-to-select decode SHALL be a combinational sub-module booth_r4_recoder, instantiated once.

Verification (BITLEN=5)
REQ-030 in_m=00011, in_q=0101, in_m_neg=11101 strobed with the start -> out_prod=8'h0F (15), strobe at edge j+3.
REQ-031 in_m=11100, in_m_neg=00100, in_q=0111 -> out_prod=8'hE4 (-28).
REQ-032 in_m=11000, in_m_neg=01000, in_q=1000 -> out_prod=8'h40 (64), covering the -2M path with maximum magnitude.
REQ-033 in_m_neg strobed 3 cycles after the start -> busy stays high, no strobe, then product 15 at the latching edge +3; a second start during busy is ignored.
REQ-034 reset asserted during ACCUM -> no strobe, busy=0, out_prod=0, and the next operation is correct.
REQ-035 Build with BOOTH_NEG_LOCAL_EN, in_m=11100, in_q=0111, in_neg_valid_pulse never asserted -> 8'hE4 at start edge +3.
